// File: rtl/kosei_source_switch_ctrl_if.sv
// Source-switch control bundle: request pins in, core select/volume/status out.
interface kosei_source_switch_ctrl_if;
  logic [2:0] input_select_req;
  logic [3:0] volume_req;
  logic       audio_present;
  logic [2:0] input_select_out;
  logic [3:0] volume_out;
  logic       switch_busy;
  logic       lock_timeout;
  logic [2:0] state_o;

  // Driver side: configuration pins and core lock indication.
  modport master (
    output input_select_req, volume_req, audio_present,
    input  input_select_out, volume_out, switch_busy, lock_timeout, state_o
  );

  // Controller side.
  modport slave (
    input  input_select_req, volume_req, audio_present,
    output input_select_out, volume_out, switch_busy, lock_timeout, state_o
  );
endinterface

// File: rtl/kosei_source_switch_ctrl.sv
// Click-free audio source switching: debounce request, ramp down, switch,
// wait for lock, ramp back up.
module kosei_source_switch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES  = 16,
  parameter int unsigned RAMP_STEP_CYCLES = 256,
  parameter int unsigned SETTLE_CYCLES    = 1024,
  parameter int unsigned LOCK_TIMEOUT     = 1048576,
  parameter logic [2:0]  RESET_SEL        = 3'b000
) (
  input logic                       clk_ref_external,
  input logic                       rst_n,
  kosei_source_switch_ctrl_if.slave bus_if
);

  localparam int unsigned STEP_MAX = (RAMP_STEP_CYCLES > SETTLE_CYCLES) ? RAMP_STEP_CYCLES : SETTLE_CYCLES;
  localparam int unsigned STEP_W   = $clog2(STEP_MAX) + 1;
  localparam int unsigned LOCK_W   = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYCLES) + 1;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_RAMP_DOWN = 3'd1,
    ST_SWITCH    = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_RAMP_UP   = 3'd4,
    ST_NOLOCK    = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_sel, w_sel_nxt;
  logic [2:0]          r_target, w_target_nxt;
  logic [3:0]          r_vol, w_vol_nxt;
  logic                r_lto, w_lto_nxt;
  logic                r_busy;
  logic [STEP_W-1:0]   r_step_cnt, w_step_nxt;
  logic [LOCK_W-1:0]   r_lock_cnt, w_lock_nxt;
  logic [2:0]          r_req_prev;
  logic [DEB_W-1:0]    r_deb_cnt;
  logic                w_enter;
  logic                w_accept;
  logic                w_acc_new;
  logic                w_ramp_last;
  logic                w_settle_last;
  logic                w_lock_last;

  // Debounce: count stable cycles of the raw request, saturating after acceptance.
  always_ff @(posedge clk_ref_external or negedge rst_n) begin
    if (!rst_n) begin
      r_req_prev <= RESET_SEL;
      r_deb_cnt  <= '0;
    end else if (bus_if.input_select_req != r_req_prev) begin
      r_req_prev <= bus_if.input_select_req;
      r_deb_cnt  <= '0;
    end else if (r_deb_cnt != DEB_W'(DEBOUNCE_CYCLES)) begin
      r_deb_cnt  <= r_deb_cnt + DEB_W'(1);
    end
  end

  assign w_accept      = (bus_if.input_select_req == r_req_prev) &&
                         (r_deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
  assign w_acc_new     = w_accept && (bus_if.input_select_req != r_sel);
  assign w_ramp_last   = (r_step_cnt == STEP_W'(RAMP_STEP_CYCLES - 1));
  assign w_settle_last = (r_step_cnt == STEP_W'(SETTLE_CYCLES - 1));
  assign w_lock_last   = (r_lock_cnt == LOCK_W'(LOCK_TIMEOUT - 1));

  // Next-state and next-output decode; any state entry clears both counters.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_target_nxt = r_target;
    w_vol_nxt    = r_vol;
    w_lto_nxt    = r_lto;
    w_step_nxt   = r_step_cnt;
    w_lock_nxt   = r_lock_cnt;
    w_enter      = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_vol_nxt = bus_if.volume_req;
        if (w_acc_new) begin
          w_target_nxt = bus_if.input_select_req;
          w_state_nxt  = ST_RAMP_DOWN;
          w_enter      = 1'b1;
        end
      end
      ST_RAMP_DOWN: begin
        if (w_accept && !w_acc_new) begin
          // Request returned to the current source: no switch needed.
          w_target_nxt = r_sel;
          w_state_nxt  = ST_RAMP_UP;
          w_enter      = 1'b1;
        end else begin
          if (w_acc_new) w_target_nxt = bus_if.input_select_req;
          if (r_vol == 4'd0) begin
            w_sel_nxt   = w_target_nxt;
            w_state_nxt = ST_SWITCH;
            w_enter     = 1'b1;
          end else if (w_ramp_last) begin
            w_vol_nxt  = r_vol - 4'd1;
            w_step_nxt = '0;
            if (r_vol == 4'd1) begin
              w_sel_nxt   = w_target_nxt;
              w_state_nxt = ST_SWITCH;
              w_enter     = 1'b1;
            end
          end else begin
            w_step_nxt = r_step_cnt + STEP_W'(1);
          end
        end
      end
      ST_SWITCH: begin
        w_vol_nxt = 4'd0;
        if (w_acc_new) begin
          w_target_nxt = bus_if.input_select_req;
          w_sel_nxt    = bus_if.input_select_req;
          w_enter      = 1'b1;
        end else if (w_settle_last) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_enter     = 1'b1;
        end else begin
          w_step_nxt = r_step_cnt + STEP_W'(1);
        end
      end
      ST_WAIT_LOCK, ST_NOLOCK: begin
        w_vol_nxt = 4'd0;
        if (w_acc_new) begin
          w_target_nxt = bus_if.input_select_req;
          w_sel_nxt    = bus_if.input_select_req;
          w_state_nxt  = ST_SWITCH;
          w_enter      = 1'b1;
        end else if (bus_if.audio_present) begin
          w_lto_nxt   = 1'b0;
          w_state_nxt = ST_RAMP_UP;
          w_enter     = 1'b1;
        end else if (r_state == ST_WAIT_LOCK) begin
          if (w_lock_last) begin
            w_lto_nxt   = 1'b1;
            w_state_nxt = ST_NOLOCK;
            w_enter     = 1'b1;
          end else begin
            w_lock_nxt = r_lock_cnt + LOCK_W'(1);
          end
        end
      end
      ST_RAMP_UP: begin
        if (w_acc_new) begin
          w_target_nxt = bus_if.input_select_req;
          w_state_nxt  = ST_RAMP_DOWN;
          w_enter      = 1'b1;
        end else if (!bus_if.audio_present) begin
          w_vol_nxt   = 4'd0;
          w_state_nxt = ST_WAIT_LOCK;
          w_enter     = 1'b1;
        end else if (bus_if.volume_req <= r_vol) begin
          w_vol_nxt   = bus_if.volume_req;
          w_state_nxt = ST_RUN;
          w_enter     = 1'b1;
        end else if (w_ramp_last) begin
          w_vol_nxt  = r_vol + 4'd1;
          w_step_nxt = '0;
          if ((r_vol + 4'd1) == bus_if.volume_req) begin
            w_state_nxt = ST_RUN;
            w_enter     = 1'b1;
          end
        end else begin
          w_step_nxt = r_step_cnt + STEP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
        w_enter     = 1'b1;
      end
    endcase
    if (w_enter) begin
      w_step_nxt = '0;
      w_lock_nxt = '0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk_ref_external or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT_LOCK;
      r_sel      <= RESET_SEL;
      r_target   <= RESET_SEL;
      r_vol      <= 4'd0;
      r_lto      <= 1'b0;
      r_busy     <= 1'b1;
      r_step_cnt <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_target   <= w_target_nxt;
      r_vol      <= w_vol_nxt;
      r_lto      <= w_lto_nxt;
      r_busy     <= (w_state_nxt != ST_RUN);
      r_step_cnt <= w_step_nxt;
      r_lock_cnt <= w_lock_nxt;
    end
  end

  assign bus_if.input_select_out = r_sel;
  assign bus_if.volume_out       = r_vol;
  assign bus_if.switch_busy      = r_busy;
  assign bus_if.lock_timeout     = r_lto;
  assign bus_if.state_o          = 3'(r_state);

endmodule
